// File: rtl/paicore_lb_stream_src.sv
// Loopback traffic source: arms the send engine, streams N numbered 64-bit frames
// ({seed, index}) on an AXI4-Stream master, then waits for tx-done, with a stall watchdog.
module paicore_lb_stream_src #(
    parameter int          DATA_WIDTH     = 64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [31:0]           i_frame_num,
    input  logic [31:0]           i_seed,
    input  logic                  i_tx_done,
    output logic                  o_fork_enable,
    output logic [31:0]           o_send_len,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_beat_cnt
);

    generate
        if (DATA_WIDTH != 64) begin : g_bad_width
            $error("paicore_lb_stream_src: DATA_WIDTH must be 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SEND, S_WAIT_TX, S_DONE, S_ERR
    } state_t;

    state_t                r_state;
    logic [31:0]           r_n_m1;
    logic [31:0]           r_seed;
    logic [31:0]           r_wd;
    logic                  r_tx_flag;
    logic                  r_fork_enable;
    logic [31:0]           r_send_len;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic [31:0]           r_beat_cnt;

    logic w_hs;
    logic w_wd_expire;
    logic w_run_state;

    assign w_hs        = r_tvalid & m_axis_tready;
    assign w_wd_expire = (r_wd == TIMEOUT_CYCLES - 32'd1);
    assign w_run_state = (r_state == S_ARM) || (r_state == S_SEND) || (r_state == S_WAIT_TX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_n_m1        <= '0;
            r_seed        <= '0;
            r_wd          <= '0;
            r_tx_flag     <= 1'b0;
            r_fork_enable <= 1'b0;
            r_send_len    <= '0;
            r_tdata       <= '0;
            r_tlast       <= 1'b0;
            r_tvalid      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_beat_cnt    <= '0;
        end else begin
            r_fork_enable <= 1'b0;
            // tx-done may arrive any time after arming; hold it until the run ends
            r_tx_flag     <= w_run_state ? (r_tx_flag | i_tx_done) : 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_err      <= 1'b0;
                        r_beat_cnt <= '0;
                        r_wd       <= '0;
                        r_busy     <= 1'b1;
                        if (i_frame_num != 32'd0) begin
                            r_n_m1        <= i_frame_num - 32'd1;
                            r_seed        <= i_seed;
                            r_send_len    <= i_frame_num;
                            r_fork_enable <= 1'b1;
                            r_state       <= S_ARM;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_ARM: begin
                    r_tvalid <= 1'b1;
                    r_tdata  <= {r_seed, 32'd0};
                    r_tlast  <= (r_n_m1 == 32'd0);
                    r_state  <= S_SEND;
                end

                S_SEND: begin
                    if (w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        r_wd       <= '0;
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_state  <= S_WAIT_TX;
                        end else begin
                            r_tdata <= {r_seed, r_beat_cnt + 32'd1};
                            r_tlast <= (r_beat_cnt + 32'd1 == r_n_m1);
                        end
                    end else if (w_wd_expire) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_ERR;
                    end else begin
                        r_wd <= r_wd + 32'd1;
                    end
                end

                S_WAIT_TX: begin
                    if (r_tx_flag || i_tx_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_wd_expire) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wd <= r_wd + 32'd1;
                    end
                end

                // A completed run enters with o_done already raised; the zero-length
                // shortcut enters with it low and raises it on the way out.
                S_DONE: begin
                    r_done  <= ~r_done;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_fork_enable = r_fork_enable;
    assign o_send_len    = r_send_len;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_paicore_lb_stream_src.sv
// Bench for paicore_lb_stream_src: timeline-based reference model checked every cycle,
// directed scenarios with literal latency pins, then a randomized traffic phase.
module tb_paicore_lb_stream_src;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_frame_num;
    logic [31:0] i_seed;
    logic        i_tx_done;
    logic        o_fork_enable;
    logic [31:0] o_send_len;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_beat_cnt;

    paicore_lb_stream_src #(
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_frame_num   (i_frame_num),
        .i_seed        (i_seed),
        .i_tx_done     (i_tx_done),
        .o_fork_enable (o_fork_enable),
        .o_send_len    (o_send_len),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_beat_cnt    (o_beat_cnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (run timeline) ----------------
    // A run started in cycle c0 arms in c0+1 and streams from c0+2; m_h is the number
    // of frames accepted so far; completion/abort cycle is derived from the last beat
    // cycle m_l, the first tx-done cycle m_t and stall counts.
    bit          chk_en = 1'b0;
    bit          m_started, m_run, m_zero, m_aborted, m_err;
    logic [31:0] m_n, m_s, m_h, m_send_len;
    int          m_c0, m_l, m_t, m_done_c, m_stall;

    bit          e_fork, e_valid, e_last, e_done, e_busy;
    logic [63:0] e_data;

    // events observed on the DUT, for the literal pins
    int          ev_fork_c, ev_first_hs_c, ev_last_c, ev_done_c, ev_nhs;
    logic [63:0] ev_last_data;

    task automatic model_abort();
        m_aborted = 1'b1;
        m_err     = 1'b1;
        m_done_c  = cyc + 1;
    endtask

    always @(negedge clk) begin
        e_fork  = m_run && (cyc == m_c0 + 1);
        e_valid = m_run && (cyc >= m_c0 + 2) && (m_h < m_n) && !m_aborted;
        e_data  = {m_s, m_h};
        e_last  = (m_h == m_n - 32'd1);
        e_done  = (m_done_c >= 0) && (cyc == m_done_c);
        e_busy  = m_started && (cyc >= m_c0 + 1) &&
                  (m_zero ? (cyc == m_c0 + 1) : ((m_done_c < 0) || (cyc <= m_done_c)));

        if (chk_en) begin
            chk("fork_enable", o_fork_enable, e_fork);
            chk("tvalid", m_axis_tvalid, e_valid);
            chk("busy", o_busy, e_busy);
            chk("done", o_done, e_done);
            chk("err", o_err, m_err);
            chk("send_len", o_send_len, m_send_len);
            chk("beat_cnt", o_beat_cnt, m_h);
            if (e_valid) begin
                chk("tdata", m_axis_tdata, e_data);
                chk("tlast", m_axis_tlast, e_last);
            end
            if (o_fork_enable) ev_fork_c = cyc;
            if (o_done) ev_done_c = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                ev_nhs++;
                if (ev_first_hs_c < 0) ev_first_hs_c = cyc;
                if (m_axis_tlast) begin
                    ev_last_c    = cyc;
                    ev_last_data = m_axis_tdata;
                end
            end
        end

        // advance the model with this cycle's inputs
        if (rst) begin
            chk_en     = 1'b1;
            m_started  = 1'b0;
            m_run      = 1'b0;
            m_zero     = 1'b0;
            m_aborted  = 1'b0;
            m_err      = 1'b0;
            m_h        = '0;
            m_n        = '0;
            m_s        = '0;
            m_send_len = '0;
            m_done_c   = -1;
            m_c0       = 0;
        end else if (!e_busy && i_start) begin
            m_started = 1'b1;
            m_c0      = cyc;
            m_h       = '0;
            m_err     = 1'b0;
            m_aborted = 1'b0;
            m_l       = -1;
            m_t       = -1;
            m_stall   = 0;
            m_done_c  = -1;
            if (i_frame_num != 32'd0) begin
                m_run      = 1'b1;
                m_zero     = 1'b0;
                m_n        = i_frame_num;
                m_s        = i_seed;
                m_send_len = i_frame_num;
            end else begin
                m_run    = 1'b0;
                m_zero   = 1'b1;
                m_done_c = cyc + 2;
            end
        end else if (m_run && e_busy) begin
            if (i_tx_done && m_t < 0) m_t = cyc;
            if (e_valid) begin
                if (m_axis_tready) begin
                    m_h     = m_h + 32'd1;
                    m_stall = 0;
                    if (m_h == m_n) m_l = cyc;
                end else begin
                    m_stall++;
                    if (m_stall == TO) model_abort();
                end
            end else if (m_l >= 0 && m_done_c < 0) begin
                if (m_t >= 0) m_done_c = cyc + 1;
                else if (cyc - m_l == TO) model_abort();
            end
        end
    end

    // ---------------- driver tasks ----------------
    int st_c;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        ev_fork_c     = -1;
        ev_first_hs_c = -1;
        ev_last_c     = -1;
        ev_done_c     = -1;
        ev_nhs        = 0;
        ev_last_data  = '0;
    endtask

    task automatic do_start(input logic [31:0] n, input logic [31:0] s);
        i_start     = 1'b1;
        i_frame_num = n;
        i_seed      = s;
        st_c        = cyc;
        tick();
        i_start = 1'b0;
    endtask

    // Run until o_done is seen; optionally randomize tready and pulse tx_done
    // tx_delay cycles after the tlast handshake (tx_delay < 0: no pulse).
    task automatic wait_run(input bit rand_rdy, input int tx_delay);
        int guard;
        guard = 0;
        while (ev_done_c < 0 && guard < 300) begin
            if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
            i_tx_done = (tx_delay >= 0) && (ev_last_c >= 0) && (cyc == ev_last_c + tx_delay);
            tick();
            guard++;
        end
        i_tx_done = 1'b0;
        chk("run_completes", 64'(ev_done_c >= 0), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst           = 1'b1;
        i_start       = 1'b0;
        i_frame_num   = '0;
        i_seed        = '0;
        i_tx_done     = 1'b0;
        m_axis_tready = 1'b0;
        clear_ev();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);

        // basic run
        clear_ev();
        m_axis_tready = 1'b1;
        do_start(32'd4, 32'hA5A5A5A5);
        wait_run(1'b0, 3);
        chk("basic_fork_lat", 64'(ev_fork_c - st_c), 64'd1);
        chk("basic_first_beat", 64'(ev_first_hs_c - st_c), 64'd2);
        chk("basic_last_beat", 64'(ev_last_c - st_c), 64'd5);
        chk("basic_last_data", ev_last_data, 64'hA5A5A5A5_00000003);
        chk("basic_done_lat", 64'(ev_done_c - ev_last_c), 64'd4);
        chk("basic_beat_cnt", 64'(o_beat_cnt), 64'd4);
        chk("basic_send_len", 64'(o_send_len), 64'd4);
        chk("basic_err", 64'(o_err), 64'd0);

        // backpressure
        clear_ev();
        do_start(32'd3, 32'h1234ABCD);
        wait_run(1'b1, 1);
        m_axis_tready = 1'b1;
        chk("bp_handshakes", 64'(ev_nhs), 64'd3);
        chk("bp_last_data", ev_last_data, 64'h1234ABCD_00000002);

        // early tx-done, coincident with the second handshake
        clear_ev();
        do_start(32'd2, 32'h0BADF00D);
        tick();
        tick();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        wait_run(1'b0, -1);
        chk("early_last_beat", 64'(ev_last_c - st_c), 64'd3);
        chk("early_done_lat", 64'(ev_done_c - ev_last_c), 64'd2);

        // zero length
        clear_ev();
        do_start(32'd0, 32'hFFFF0000);
        wait_run(1'b0, -1);
        chk("zero_no_fork", 64'(ev_fork_c < 0), 64'd1);
        chk("zero_no_beats", 64'(ev_nhs), 64'd0);
        chk("zero_done_lat", 64'(ev_done_c - st_c), 64'd2);

        // timeout, then a clean restart
        clear_ev();
        m_axis_tready = 1'b0;
        do_start(32'd5, 32'h55AA55AA);
        wait_run(1'b0, -1);
        chk("to_done_lat", 64'(ev_done_c - st_c), 64'd18);
        chk("to_err", 64'(o_err), 64'd1);
        chk("to_no_beats", 64'(ev_nhs), 64'd0);
        clear_ev();
        m_axis_tready = 1'b1;
        do_start(32'd2, 32'h77777777);
        chk("restart_err_clr", 64'(o_err), 64'd0);
        wait_run(1'b0, 1);
        chk("restart_beats", 64'(ev_nhs), 64'd2);

        // reset mid-SEND, then start-while-busy ignored
        clear_ev();
        do_start(32'd8, 32'hDEAD0001);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_send_len", 64'(o_send_len), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        tick();
        clear_ev();
        do_start(32'd8, 32'hBEEF0002);
        tick();
        i_start     = 1'b1;
        i_frame_num = 32'd3;
        i_seed      = 32'h99999999;
        tick();
        i_start = 1'b0;
        wait_run(1'b0, 1);
        chk("busy_start_len", 64'(o_send_len), 64'd8);
        chk("busy_start_beats", 64'(ev_nhs), 64'd8);
        chk("busy_start_data", ev_last_data, 64'hBEEF0002_00000007);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            i_start       = ($urandom_range(0, 5) == 0);
            i_frame_num   = $urandom_range(0, 6);
            i_seed        = $urandom;
            m_axis_tready = (i < 300) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
            i_tx_done     = ($urandom_range(0, 7) == 0);
            tick();
        end
        i_start       = 1'b0;
        m_axis_tready = 1'b1;
        i_tx_done     = 1'b0;
        repeat (40) tick();
        chk("final_idle", 64'(o_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
